// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and SRAM buses around mem_arbiter.
// slave is the arbiter side, master the requester/SRAM side.
interface mem_arbiter_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_valid;
  logic        im_stall;
  logic        dm_req;
  logic        dm_web;
  logic [31:0] dm_bweb;
  logic [31:0] dm_addr;
  logic [31:0] dm_di;
  logic [31:0] dm_do;
  logic        dm_valid;
  logic        dm_stall;
  logic        sram_ceb;
  logic        sram_web;
  logic [31:0] sram_bweb;
  logic [31:0] sram_addr;
  logic [31:0] sram_di;
  logic [31:0] sram_do;

  modport slave (
    input  im_req, im_addr,
    input  dm_req, dm_web, dm_bweb, dm_addr, dm_di,
    input  sram_do,
    output im_rdata, im_valid, im_stall,
    output dm_do, dm_valid, dm_stall,
    output sram_ceb, sram_web, sram_bweb, sram_addr, sram_di
  );

  modport master (
    output im_req, im_addr,
    output dm_req, dm_web, dm_bweb, dm_addr, dm_di,
    output sram_do,
    input  im_rdata, im_valid, im_stall,
    input  dm_do, dm_valid, dm_stall,
    input  sram_ceb, sram_web, sram_bweb, sram_addr, sram_di
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data access.
// DM has priority; IM wins after STARVE_MAX DM grants while it waits.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 2
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [1:0] SMAX = 2'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [1:0]  streak_q, streak_d;
  logic        own_dm_q, own_dm_d;
  logic        rd_q, rd_d;
  logic        ceb_q, ceb_d;
  logic        web_q, web_d;
  logic [31:0] bweb_q, bweb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] di_q, di_d;
  logic        imv_q, imv_d;
  logic        dmv_q, dmv_d;
  logic [31:0] imr_q, imr_d;
  logic [31:0] dmr_q, dmr_d;
  logic        pick_im;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      own_dm_q <= 1'b0;
      rd_q     <= 1'b1;
      ceb_q    <= 1'b1;
      web_q    <= 1'b1;
      bweb_q   <= '1;
      addr_q   <= '0;
      di_q     <= '0;
      imv_q    <= 1'b0;
      dmv_q    <= 1'b0;
      imr_q    <= '0;
      dmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      own_dm_q <= own_dm_d;
      rd_q     <= rd_d;
      ceb_q    <= ceb_d;
      web_q    <= web_d;
      bweb_q   <= bweb_d;
      addr_q   <= addr_d;
      di_q     <= di_d;
      imv_q    <= imv_d;
      dmv_q    <= dmv_d;
      imr_q    <= imr_d;
      dmr_q    <= dmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    own_dm_d = own_dm_q;
    rd_d     = rd_q;
    ceb_d    = 1'b1;
    web_d    = 1'b1;
    bweb_d   = '1;
    addr_d   = addr_q;
    di_d     = di_q;
    imv_d    = 1'b0;
    dmv_d    = 1'b0;
    imr_d    = imr_q;
    dmr_d    = dmr_q;
    pick_im  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.im_req || bus.dm_req) begin
          pick_im = bus.im_req &
                    (~bus.dm_req | (streak_q == SMAX));
          state_d  = ACCESS;
          ceb_d    = 1'b0;
          own_dm_d = ~pick_im;
          if (pick_im) begin
            addr_d   = bus.im_addr;
            di_d     = '0;
            rd_d     = 1'b1;
            streak_d = '0;
          end else begin
            addr_d = bus.dm_addr;
            web_d  = bus.dm_web;
            bweb_d = bus.dm_bweb;
            di_d   = bus.dm_di;
            rd_d   = bus.dm_web;
            // streak only counts DM wins that made IM wait
            if (bus.im_req && streak_q != 2'd3)
              streak_d = streak_q + 2'd1;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        imv_d   = ~own_dm_q;
        dmv_d   = own_dm_q;
      end
      RESP: begin
        state_d = IDLE;
        if (rd_q) begin
          if (own_dm_q) dmr_d = bus.sram_do;
          else          imr_d = bus.sram_do;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sram_do arrives during RESP, so read data bypasses its register there
  assign bus.im_rdata  = imv_q ? bus.sram_do : imr_q;
  assign bus.dm_do     = (dmv_q && rd_q) ? bus.sram_do : dmr_q;
  assign bus.im_valid  = imv_q;
  assign bus.dm_valid  = dmv_q;
  assign bus.im_stall  = bus.im_req & ~imv_q;
  assign bus.dm_stall  = bus.dm_req & ~dmv_q;
  assign bus.sram_ceb  = ceb_q;
  assign bus.sram_web  = web_q;
  assign bus.sram_bweb = bweb_q;
  assign bus.sram_addr = addr_q;
  assign bus.sram_di   = di_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 2: maximum consecutive DM grants while IM is pending.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-004 SHALL have im_req in 1 (fetch request); im_addr in 32; im_rdata out 32; im_valid out 1 (1-cycle completion pulse); im_stall out 1.
REQ-005 SHALL have dm_req in 1; dm_web in 1 (0=write, 1=read); dm_bweb in 32 (active-low bit write mask); dm_addr in 32; dm_di in 32; dm_do out 32; dm_valid out 1; dm_stall out 1.
REQ-006 SHALL have sram_ceb out 1 (active-low enable); sram_web out 1; sram_bweb out 32; sram_addr out 32; sram_di out 32; sram_do in 32 (valid the cycle after an enabled read).

Function
REQ-007 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight at a time.
REQ-008 IDLE: if any req is high, SHALL latch the winner's addr/web/bweb/di and owner flag, then go to ACCESS; otherwise stay in IDLE.
REQ-009 Arbitration: DM wins over IM, except when both requests are pending and streak == STARVE_MAX, in which case IM wins.
REQ-010 streak: 2-bit saturating counter. On DM grant with im_req high: +1. On any IM grant: cleared. On DM grant with im_req low: unchanged.
REQ-011 ACCESS: sram_ceb=0; sram_addr/web/bweb/di driven from latched values, all registered outputs; next state RESP.
REQ-012 RESP: owner's rdata register SHALL capture sram_do (reads only); owner's valid pulses high exactly 1 cycle; next state IDLE.
REQ-013 Writes SHALL also pulse dm_valid in RESP; dm_do holds its previous value.
REQ-014 Outside ACCESS: sram_ceb=1, sram_web=1, sram_bweb=all ones.
REQ-015 Latency from req sampled in IDLE to valid SHALL be 2 cycles (valid in the 3rd cycle); back-to-back throughput is 1 transaction per 3 cycles.
REQ-016 im_stall = im_req & ~im_valid; dm_stall = dm_req & ~dm_valid (combinational).
REQ-017 Requester holds req and payload until valid; payload changes after the latch are ignored.
REQ-018 If req drops mid-transaction, the transaction SHALL still complete and valid still pulses.
REQ-019 im_rdata and dm_do SHALL hold their last captured value until the next read completes for that owner.
REQ-020 A request rising in RESP SHALL be arbitrated in the following IDLE cycle; there is no IDLE bypass.

Reset
REQ-021 While rst=0 at a clock edge: state=IDLE, streak=0, im_valid=dm_valid=0, im_rdata=dm_do=0, sram_ceb=1, sram_web=1, sram_bweb=all ones, sram_addr=sram_di=0.
REQ-022 Reset asserted mid-transaction SHALL abort it with no valid pulse; after release, a still-pending req is re-arbitrated from IDLE.

Verification
REQ-023 IM-only read, im_addr=0x100, sram_do=0xDEADBEEF -> sram_ceb=0 in cycle 2 with addr 0x100; im_valid=1 with im_rdata=0xDEADBEEF in cycle 3; dm_valid stays 0.
REQ-024 Simultaneous im_req/dm_req held high, STARVE_MAX=2 -> grant order DM, DM, IM, DM, DM, IM; streak returns to 0 after each IM grant.
REQ-025 DM write, dm_web=0, dm_bweb=0xFFFF00FF, dm_di=0x12345678, addr=0x2000 -> ACCESS drives identical values with sram_web=0; dm_valid pulses; dm_do unchanged.
REQ-026 Reset asserted during ACCESS of a DM read -> next cycle sram_ceb=1, no dm_valid; after release with dm_req still high -> new ACCESS 1 cycle later.
REQ-027 im_req dropped in the cycle after IDLE grant -> im_valid still pulses in RESP; IDLE then stays idle with sram_ceb=1.
